// File: rtl/d_mem_pipe.sv
// Single-port data memory with a valid/ready request port and a fixed-latency,
// in-order response pipeline. Self-initialises to word i = i after every reset.
module d_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [AW-1:0]     init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge; reset here is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == AW'(DEPTH - 1)) state <= ST_RUN;
    end
  end

  assign init_done = (state == ST_RUN);
  assign req_ready = init_done;

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              err;
  logic [ADDR_W-1:0] word_addr;
  logic [AW-1:0]     idx;
  logic              wr_en;
  logic              rd_en;

  assign accept       = req_valid & req_ready;
  assign misaligned   = (req_addr & ADDR_W'(BE_W - 1)) != '0;
  assign word_addr    = req_addr >> OFF_W;
  assign out_of_range = word_addr >= ADDR_W'(DEPTH);
  assign err          = misaligned | out_of_range;
  assign idx          = word_addr[AW-1:0];
  assign wr_en        = accept & req_write & ~err;
  assign rd_en        = accept & ~req_write & ~err;

  // NOTE: the array has no reset branch; the INIT pass rewrites every word, so
  // it maps onto plain RAM instead of a wide bank of resettable flops.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt] <= DATA_W'(init_cnt);
    end else if (wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  // Stage 0 captures the response at the accept edge; idle stages carry zeros
  // so the outputs are clean whenever rsp_valid is low.
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_err;
  logic [DATA_W-1:0] pipe_data [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & err;
      pipe_data[0]  <= rd_en ? mem[idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[RD_LAT-1];
  assign rsp_err   = pipe_err[RD_LAT-1];
  assign rsp_rdata = pipe_data[RD_LAT-1];

endmodule
